clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_ctrl_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/clock_set_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared mode encoding, time-field limits and wrap helper for clock_set_ctrl.
package clock_ctrl_pkg;

  localparam int unsigned TIME_W = 6;

  localparam logic [TIME_W-1:0] MAX_HRS  = 6'd23;
  localparam logic [TIME_W-1:0] MAX_MINS = 6'd59;
  localparam logic [TIME_W-1:0] MAX_SECS = 6'd59;

  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;
  localparam logic [1:0] MODE_COMMIT  = 2'd3;

  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] val,
                                                 input logic [TIME_W-1:0] max);
    return (val >= max) ? '0 : val + TIME_W'(1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while run is high.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!run) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting mode controller with prescaled tick and load strobe to the time counter.
// Optional alarm comparator enabled by defining CLOCK_CTRL_ALARM_EN.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic [TIME_W-1:0] cur_hrs,
  input  logic [TIME_W-1:0] cur_mins,
  input  logic [TIME_W-1:0] cur_secs,
  output logic              tick_en,
  output logic              load_en,
  output logic [TIME_W-1:0] load_hrs,
  output logic [TIME_W-1:0] load_mins,
  output logic [TIME_W-1:0] load_secs,
  output logic [1:0]        mode,
  output logic [TIME_W-1:0] disp_hrs,
  output logic [TIME_W-1:0] disp_mins,
  input  logic              alarm_arm,
  input  logic [TIME_W-1:0] alarm_hrs,
  input  logic [TIME_W-1:0] alarm_mins,
  input  logic              alarm_ack,
  output logic              alarm
);

  logic [1:0]        r_mode;
  logic [TIME_W-1:0] r_shadow_hrs, r_shadow_mins;
  logic              r_load_en;
  logic [TIME_W-1:0] r_load_hrs, r_load_mins;
  logic [TIME_W-1:0] r_disp_hrs, r_disp_mins;

  logic [1:0]        w_next_mode;
  logic [TIME_W-1:0] w_next_shadow_hrs, w_next_shadow_mins;
  logic              w_run_next;
  logic              w_tick;

  always_comb begin
    w_next_mode        = r_mode;
    w_next_shadow_hrs  = r_shadow_hrs;
    w_next_shadow_mins = r_shadow_mins;
    case (r_mode)
      MODE_RUN: begin
        if (mode_btn) begin
          w_next_mode        = MODE_SET_HR;
          w_next_shadow_hrs  = cur_hrs;
          w_next_shadow_mins = cur_mins;
        end
      end
      MODE_SET_HR: begin
        if (mode_btn)     w_next_mode       = MODE_SET_MIN;
        else if (inc_btn) w_next_shadow_hrs = inc_wrap(r_shadow_hrs, MAX_HRS);
      end
      MODE_SET_MIN: begin
        if (mode_btn)     w_next_mode        = MODE_COMMIT;
        else if (inc_btn) w_next_shadow_mins = inc_wrap(r_shadow_mins, MAX_MINS);
      end
      default: w_next_mode = MODE_RUN;
    endcase
  end

  // Prescaler follows the next mode so the registered tick never lands in a non-RUN cycle.
  assign w_run_next = (w_next_mode == MODE_RUN);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (w_run_next),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_RUN;
      r_shadow_hrs  <= '0;
      r_shadow_mins <= '0;
      r_load_en     <= 1'b0;
      r_load_hrs    <= '0;
      r_load_mins   <= '0;
      r_disp_hrs    <= '0;
      r_disp_mins   <= '0;
    end else begin
      r_mode        <= w_next_mode;
      r_shadow_hrs  <= w_next_shadow_hrs;
      r_shadow_mins <= w_next_shadow_mins;
      r_load_en     <= (w_next_mode == MODE_COMMIT);
      if (w_next_mode == MODE_COMMIT) begin
        r_load_hrs  <= w_next_shadow_hrs;
        r_load_mins <= w_next_shadow_mins;
      end
      if ((w_next_mode == MODE_SET_HR) || (w_next_mode == MODE_SET_MIN)) begin
        r_disp_hrs  <= w_next_shadow_hrs;
        r_disp_mins <= w_next_shadow_mins;
      end else begin
        r_disp_hrs  <= cur_hrs;
        r_disp_mins <= cur_mins;
      end
    end
  end

  assign tick_en   = w_tick;
  assign load_en   = r_load_en;
  assign load_hrs  = r_load_hrs;
  assign load_mins = r_load_mins;
  assign load_secs = '0;
  assign mode      = r_mode;
  assign disp_hrs  = r_disp_hrs;
  assign disp_mins = r_disp_mins;

`ifdef CLOCK_CTRL_ALARM_EN
  logic [TIME_W-1:0] w_nxt_hrs, w_nxt_mins;
  logic              w_alarm_hit;
  logic              r_alarm;

  // Match against the time the counter will show after this tick (cur + 1 s).
  always_comb begin
    w_nxt_mins  = inc_wrap(cur_mins, MAX_MINS);
    w_nxt_hrs   = (cur_mins >= MAX_MINS) ? inc_wrap(cur_hrs, MAX_HRS) : cur_hrs;
    w_alarm_hit = (cur_secs >= MAX_SECS) && (w_nxt_mins == alarm_mins) &&
                  (w_nxt_hrs == alarm_hrs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            r_alarm <= 1'b0;
    else if (!alarm_arm || alarm_ack)                      r_alarm <= 1'b0;
    else if ((r_mode == MODE_RUN) && w_tick && w_alarm_hit) r_alarm <= 1'b1;
  end

  assign alarm = r_alarm;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{alarm_arm, alarm_hrs, alarm_mins, alarm_ack, cur_secs};
  assign alarm          = 1'b0;
`endif

endmodule
